// File: rtl/hash_job_sequencer.sv
// hash_job_sequencer
//   Turns one BLAKE2 hash job (kk/nn/ll plus a message byte stream) into the
//   byte-wide command stream of the hash core. It sends the config bytes, then
//   zero-padded BLOCK_BYTES-sized blocks, and returns the nn digest bytes.
//
// Ports
//   clk, rst          core clock, synchronous active-high reset
//   job_*             job request handshake (valid/ready) with kk, nn, ll
//   src_*             message byte stream (valid/ready)
//   core_data_o       byte to the core (ui_in)
//   core_ctrl_o       {valid, cmd[1:0]} to the core (uio_in[2:0])
//   core_ready_i      core accepts a beat (uio_out[3])
//   core_hash_v_i     digest byte valid (uio_out[7])
//   core_hash_i       digest byte (uo_out)
//   res_*             digest byte strobe with last marker, no backpressure
//   busy_o, err_o     job in flight / sticky error
//
// Optional feature: define HASH_TIMEOUT_EN to add a watchdog that aborts the
// job after TIMEOUT_CYC cycles without core progress.

module hash_job_sequencer #(
    parameter int unsigned BLOCK_BYTES = 64,
    parameter int unsigned LL_W        = 16,
`ifdef HASH_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYC = 4096,
`endif
    parameter int unsigned NN_MAX      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            job_valid_i,
    output logic            job_ready_o,
    input  logic [7:0]      job_kk_i,
    input  logic [5:0]      job_nn_i,
    input  logic [LL_W-1:0] job_ll_i,
    input  logic            src_valid_i,
    input  logic [7:0]      src_data_i,
    output logic            src_ready_o,
    output logic [7:0]      core_data_o,
    output logic [2:0]      core_ctrl_o,
    input  logic            core_ready_i,
    input  logic            core_hash_v_i,
    input  logic [7:0]      core_hash_i,
    output logic            res_valid_o,
    output logic [7:0]      res_data_o,
    output logic            res_last_o,
    output logic            busy_o,
    output logic            err_o
);

    localparam int unsigned OFF_W = $clog2(BLOCK_BYTES);
    localparam int unsigned POS_W = LL_W + 1;
    localparam int unsigned NCFG  = 2 + LL_W / 8;
    localparam int unsigned CFG_W = $clog2(NCFG + 1);
`ifdef HASH_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);
`endif

    localparam logic [1:0] CMD_CFG  = 2'b00;
    localparam logic [1:0] CMD_BLK  = 2'b01;
    localparam logic [1:0] CMD_LAST = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_DATA,
        S_WAIT,
        S_RESULT
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      kk_q, kk_d;
    logic [5:0]      nn_q, nn_d;
    logic [LL_W-1:0] ll_q, ll_d;
    logic [POS_W-1:0] tot_q, tot_d;
    logic [CFG_W-1:0] cfg_idx_q, cfg_idx_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [5:0]      dc_q, dc_d;
    logic [7:0]      core_data_q, core_data_d;
    logic [2:0]      core_ctrl_q, core_ctrl_d;
    logic            res_valid_q, res_valid_d;
    logic [7:0]      res_data_q, res_data_d;
    logic            res_last_q, res_last_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            job_ready_q, job_ready_d;
    logic            hv_drain_q, hv_drain_d;
`ifdef HASH_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    logic             beat_c;
    logic             out_free_c;
    logic             is_data_c;
    logic             final_blk_c;
    logic             cap_c;
    logic             src_ready_c;
    logic [7:0]       cfg_byte_c;
    logic [POS_W-1:0] tot_c;

    // Padded stream length of a new job: whole blocks, at least one.
    always_comb begin
        tot_c = ((POS_W'(job_ll_i) + POS_W'(BLOCK_BYTES - 1)) >> OFF_W) << OFF_W;
        if (job_ll_i == '0) begin
            tot_c = POS_W'(BLOCK_BYTES);
        end
    end

    // Config byte order: kk, nn, then ll least-significant byte first.
    always_comb begin
        if (cfg_idx_q == CFG_W'(0)) begin
            cfg_byte_c = kk_q;
        end else if (cfg_idx_q == CFG_W'(1)) begin
            cfg_byte_c = 8'(nn_q);
        end else begin
            cfg_byte_c = 8'(ll_q >> (32'd8 * (32'(cfg_idx_q) - 32'd2)));
        end
    end

    assign beat_c      = core_ctrl_q[2] & core_ready_i;
    assign out_free_c  = ~core_ctrl_q[2] | core_ready_i;
    assign is_data_c   = pos_q < POS_W'(ll_q);
    assign final_blk_c = pos_q >= (tot_q - POS_W'(BLOCK_BYTES));

    // Next-state and output-register logic.
    always_comb begin
        state_d     = state_q;
        kk_d        = kk_q;
        nn_d        = nn_q;
        ll_d        = ll_q;
        tot_d       = tot_q;
        cfg_idx_d   = cfg_idx_q;
        pos_d       = pos_q;
        dc_d        = dc_q;
        core_data_d = core_data_q;
        core_ctrl_d = core_ctrl_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_last_d  = 1'b0;
        err_d       = err_q;
        hv_drain_d  = hv_drain_q & core_hash_v_i;
        src_ready_c = 1'b0;
        cap_c       = 1'b0;
`ifdef HASH_TIMEOUT_EN
        tmo_d       = '0;
`endif

        // An accepted beat empties the output register unless reloaded below.
        if (beat_c) begin
            core_ctrl_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (job_valid_i && job_ready_q) begin
                    kk_d      = job_kk_i;
                    nn_d      = job_nn_i;
                    ll_d      = job_ll_i;
                    tot_d     = tot_c;
                    cfg_idx_d = '0;
                    pos_d     = '0;
                    dc_d      = '0;
                    if (job_nn_i == 6'd0 || job_nn_i > 6'(NN_MAX)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_CFG;
                    end
                end
            end
            S_CFG: begin
                if (out_free_c) begin
                    if (cfg_idx_q == CFG_W'(NCFG)) begin
                        state_d = S_DATA;
                    end else begin
                        core_data_d = cfg_byte_c;
                        core_ctrl_d = {1'b1, CMD_CFG};
                        cfg_idx_d   = cfg_idx_q + CFG_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (out_free_c) begin
                    if (pos_q == tot_q) begin
                        state_d = S_WAIT;
                    end else if (is_data_c) begin
                        src_ready_c = 1'b1;
                        if (src_valid_i) begin
                            core_data_d = src_data_i;
                            core_ctrl_d = {1'b1, final_blk_c ? CMD_LAST : CMD_BLK};
                            pos_d       = pos_q + POS_W'(1);
                        end
                    end else begin
                        // Padding only ever falls in the final block.
                        core_data_d = 8'h00;
                        core_ctrl_d = {1'b1, CMD_LAST};
                        pos_d       = pos_q + POS_W'(1);
                    end
                end
            end
            S_WAIT: begin
                // Ignore a digest still streaming from the previous job.
                if (core_hash_v_i && !hv_drain_q) begin
                    cap_c = 1'b1;
                end
            end
            S_RESULT: begin
                if (core_hash_v_i) begin
                    cap_c = 1'b1;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Digest capture; surplus bytes after the last one are drained silently.
        if (cap_c) begin
            res_valid_d = 1'b1;
            res_data_d  = core_hash_i;
            dc_d        = dc_q + 6'd1;
            state_d     = S_RESULT;
            if (dc_q == nn_q - 6'd1) begin
                res_last_d = 1'b1;
                hv_drain_d = 1'b1;
                state_d    = S_IDLE;
            end
        end

        if (core_hash_v_i && !hv_drain_q &&
            (state_q == S_IDLE || state_q == S_CFG || state_q == S_DATA)) begin
            err_d = 1'b1;
        end

`ifdef HASH_TIMEOUT_EN
        // Watchdog: counts cycles with neither a core beat nor digest output.
        if ((state_q == S_CFG || state_q == S_DATA || state_q == S_WAIT) &&
            !(beat_c || core_hash_v_i)) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                err_d       = 1'b1;
                state_d     = S_IDLE;
                core_ctrl_d = '0;
                src_ready_c = 1'b0;
                pos_d       = pos_q;
                core_data_d = core_data_q;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
`endif

        // Ready rises one cycle after returning to IDLE, so a job offered
        // alongside the final digest byte is not taken.
        job_ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
        busy_d      = state_d != S_IDLE;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            kk_q        <= '0;
            nn_q        <= '0;
            ll_q        <= '0;
            tot_q       <= '0;
            cfg_idx_q   <= '0;
            pos_q       <= '0;
            dc_q        <= '0;
            core_data_q <= '0;
            core_ctrl_q <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_last_q  <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            job_ready_q <= 1'b1;
            hv_drain_q  <= 1'b0;
`ifdef HASH_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            kk_q        <= kk_d;
            nn_q        <= nn_d;
            ll_q        <= ll_d;
            tot_q       <= tot_d;
            cfg_idx_q   <= cfg_idx_d;
            pos_q       <= pos_d;
            dc_q        <= dc_d;
            core_data_q <= core_data_d;
            core_ctrl_q <= core_ctrl_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_last_q  <= res_last_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            job_ready_q <= job_ready_d;
            hv_drain_q  <= hv_drain_d;
`ifdef HASH_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign job_ready_o = job_ready_q;
    assign src_ready_o = src_ready_c;
    assign core_data_o = core_data_q;
    assign core_ctrl_o = core_ctrl_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_last_o  = res_last_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;

endmodule
